// File: rtl/stone_ram_arbiter.sv
// Stone RAM arbiter: one renderer read port and two rope ports share a
// single-port stone RAM. Priority order is lock owner, then renderer, then
// the ropes in round-robin order. A starvation counter guarantees that
// ropes are eventually served, and a lock counter forces a release on timeout.
module stone_ram_arbiter #(
  parameter int LOCK_MAX   = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        r_req,
  input  logic [3:0]  r_addr,
  output logic        r_gnt,
  output logic        r_valid,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [3:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_valid,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [3:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_valid,
  output logic [31:0] rdata,
  output logic [3:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic        lock_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] SRC_R    = 2'd0;
  localparam logic [1:0] SRC_P0   = 2'd1;
  localparam logic [1:0] SRC_P1   = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  state_t      state_r, state_next_s;
  logic [1:0]  src_r, win_s, rope_pick_s;
  logic [3:0]  addr_r, sel_addr_s;
  logic        we_r, sel_we_s, sel_lock_s;
  logic [31:0] wdata_r, sel_wdata_s;
  logic        owner_valid_r, owner_id_r;
  logic [7:0]  lock_cnt_r, starve_cnt_r;
  logic        rr_r;
  logic        owner_lock_s, owner_req_s, lock_held_s, rope_any_s, starved_s;
  logic        arb_s, grant_s;

  // Pick the winner of this cycle's arbitration from the priority rules.
  always_comb begin
    owner_lock_s = owner_id_r ? p1_lock : p0_lock;
    owner_req_s  = owner_id_r ? p1_req  : p0_req;
    lock_held_s  = owner_valid_r & owner_lock_s;
    rope_any_s   = p0_req | p1_req;
    starved_s    = (starve_cnt_r >= 8'(STARVE_MAX)) & rope_any_s;
    if (rr_r == 1'b0) begin
      rope_pick_s = p0_req ? SRC_P0 : SRC_P1;
    end else begin
      rope_pick_s = p1_req ? SRC_P1 : SRC_P0;
    end
    if (lock_held_s) begin
      // The owner keeps exclusive access even while it has nothing to ask.
      if (owner_req_s) begin
        win_s = owner_id_r ? SRC_P1 : SRC_P0;
      end else begin
        win_s = SRC_NONE;
      end
    end else if (r_req & ~starved_s) begin
      win_s = SRC_R;
    end else if (rope_any_s) begin
      win_s = rope_pick_s;
    end else begin
      win_s = SRC_NONE;
    end
    arb_s   = (state_r == S_IDLE) | (state_r == S_RESP);
    grant_s = arb_s & (win_s != SRC_NONE);
  end

  // Select the winner's request fields; the renderer can only read.
  always_comb begin
    sel_addr_s  = 4'd0;
    sel_we_s    = 1'b0;
    sel_wdata_s = 32'd0;
    sel_lock_s  = 1'b0;
    case (win_s)
      SRC_R: begin
        sel_addr_s = r_addr;
      end
      SRC_P0: begin
        sel_addr_s  = p0_addr;
        sel_we_s    = p0_we;
        sel_wdata_s = p0_wdata;
        sel_lock_s  = p0_lock;
      end
      SRC_P1: begin
        sel_addr_s  = p1_addr;
        sel_we_s    = p1_we;
        sel_wdata_s = p1_wdata;
        sel_lock_s  = p1_lock;
      end
      default: begin
        sel_addr_s = 4'd0;
      end
    endcase
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:   state_next_s = grant_s ? S_ACCESS : S_IDLE;
      S_ACCESS: state_next_s = S_WAIT;
      S_WAIT:   state_next_s = S_RESP;
      S_RESP:   state_next_s = grant_s ? S_ACCESS : S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the winning request at the grant.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      src_r   <= SRC_NONE;
      addr_r  <= 4'd0;
      we_r    <= 1'b0;
      wdata_r <= 32'd0;
    end else if (grant_s) begin
      src_r   <= win_s;
      addr_r  <= sel_addr_s;
      we_r    <= sel_we_s;
      wdata_r <= sel_wdata_s;
    end
  end

  // Registered requester pulses, RAM drive and read-data capture.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_gnt     <= 1'b0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      r_valid   <= 1'b0;
      p0_valid  <= 1'b0;
      p1_valid  <= 1'b0;
      ram_addr  <= 4'd0;
      ram_wdata <= 32'd0;
      ram_wren  <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      r_gnt    <= grant_s & (win_s == SRC_R);
      p0_gnt   <= grant_s & (win_s == SRC_P0);
      p1_gnt   <= grant_s & (win_s == SRC_P1);
      r_valid  <= (state_r == S_RESP) & (src_r == SRC_R);
      p0_valid <= (state_r == S_RESP) & (src_r == SRC_P0);
      p1_valid <= (state_r == S_RESP) & (src_r == SRC_P1);
      ram_wren <= (state_r == S_ACCESS) & we_r;
      if (state_r == S_ACCESS) begin
        ram_addr  <= addr_r;
        ram_wdata <= wdata_r;
      end
      if (state_r == S_RESP) begin
        rdata <= ram_q;
      end
    end
  end

  // Lock ownership: acquire on a locked rope grant, release on lock low or timeout.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      owner_valid_r <= 1'b0;
      owner_id_r    <= 1'b0;
      lock_cnt_r    <= 8'd0;
      lock_timeout  <= 1'b0;
    end else begin
      lock_timeout <= 1'b0;
      if (grant_s & (win_s != SRC_R) & sel_lock_s & ~lock_held_s) begin
        owner_valid_r <= 1'b1;
        owner_id_r    <= (win_s == SRC_P1);
        lock_cnt_r    <= 8'd0;
      end else if (owner_valid_r) begin
        if (arb_s & ~lock_held_s) begin
          owner_valid_r <= 1'b0;
          lock_cnt_r    <= 8'd0;
        end else if (lock_cnt_r == 8'(LOCK_MAX - 1)) begin
          owner_valid_r <= 1'b0;
          lock_cnt_r    <= 8'd0;
          lock_timeout  <= 1'b1;
        end else begin
          lock_cnt_r <= lock_cnt_r + 8'd1;
        end
      end
    end
  end

  // Starvation counter and rope round-robin pointer.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      starve_cnt_r <= 8'd0;
      rr_r         <= 1'b0;
    end else if (grant_s) begin
      if (win_s == SRC_R) begin
        if (rope_any_s & (starve_cnt_r != 8'hFF)) begin
          starve_cnt_r <= starve_cnt_r + 8'd1;
        end else if (!rope_any_s) begin
          starve_cnt_r <= 8'd0;
        end
      end else begin
        starve_cnt_r <= 8'd0;
        rr_r         <= (win_s == SRC_P0);
      end
    end
  end

endmodule

// File: tb/tb_stone_ram_arbiter.sv
// Self-checking bench for stone_ram_arbiter with a behavioural stone RAM,
// directed scenarios and randomized traffic against a reference model.
module tb_stone_ram_arbiter;
  localparam int LOCK_MAX   = 64;
  localparam int STARVE_MAX = 8;

  logic        clock, resetn;
  logic        r_req, r_gnt, r_valid;
  logic [3:0]  r_addr;
  logic        p0_req, p0_we, p0_lock, p0_gnt, p0_valid;
  logic [3:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_valid;
  logic [3:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic [31:0] rdata, ram_wdata, ram_q;
  logic [3:0]  ram_addr;
  logic        ram_wren, lock_timeout;

  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [16];
  logic [31:0] model_mem [16];

  int checks = 0;
  int failures = 0;

  stone_ram_arbiter #(.LOCK_MAX(LOCK_MAX), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .resetn(resetn),
    .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_valid(r_valid),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_valid(p0_valid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_valid(p1_valid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .ram_q(ram_q), .lock_timeout(lock_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port stone RAM with one-cycle registered read and a bench preload port.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic gnt_of(input int src);
    return (src == 0) ? r_gnt : (src == 1) ? p0_gnt : p1_gnt;
  endfunction

  function automatic logic valid_of(input int src);
    return (src == 0) ? r_valid : (src == 1) ? p0_valid : p1_valid;
  endfunction

  task automatic clear_inputs();
    r_req = 1'b0; r_addr = 4'd0;
    p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 4'd0; p0_wdata = 32'd0;
    p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 4'd0; p1_wdata = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic set_req(input int src, input logic v, input logic [3:0] a,
                         input logic w, input logic [31:0] d);
    case (src)
      0: begin r_req = v; r_addr = a; end
      1: begin p0_req = v; p0_addr = a; p0_we = w; p0_wdata = d; end
      default: begin p1_req = v; p1_addr = a; p1_we = w; p1_wdata = d; end
    endcase
  endtask

  // One isolated access from idle; reports what was seen at each cycle.
  task automatic do_access(input int src, input logic [3:0] a, input logic w,
                           input logic [31:0] d, output logic g_ok,
                           output logic v_early, output logic v_ok,
                           output logic [31:0] rd, output int wren_n);
    wren_n = 0; v_early = 1'b0;
    set_req(src, 1'b1, a, w, d);
    tick();
    g_ok = gnt_of(src) && ((r_gnt + p0_gnt + p1_gnt) == 1);
    v_early = valid_of(src); wren_n += int'(ram_wren);
    set_req(src, 1'b0, a, w, d);
    tick(); v_early |= valid_of(src); wren_n += int'(ram_wren);
    tick(); v_early |= valid_of(src); wren_n += int'(ram_wren);
    tick(); v_ok = valid_of(src); rd = rdata; wren_n += int'(ram_wren);
  endtask

  task automatic test_reset();
    resetn = 1'b0; r_req = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
    tick(); tick();
    checks++;
    if ({r_gnt, p0_gnt, p1_gnt, r_valid, p0_valid, p1_valid, ram_wren, lock_timeout} !== 8'd0) begin
      failures++;
      $display("FAIL reset_pulses got=%b want=0",
               {r_gnt, p0_gnt, p1_gnt, r_valid, p0_valid, p1_valid, ram_wren, lock_timeout});
    end
    checks++;
    if ({rdata, ram_addr, ram_wdata} !== 68'd0) begin
      failures++;
      $display("FAIL reset_data rdata=%h ram_addr=%h ram_wdata=%h want 0", rdata, ram_addr, ram_wdata);
    end
    do_reset();
  endtask

  task automatic test_read_latency();
    logic g, ve, v; logic [31:0] rd; int wn;
    do_reset();
    preload(4'd3, 32'h1234_5678);
    r_req = 1'b1; r_addr = 4'd3;
    tick();
    checks++;
    if (r_gnt !== 1'b1) begin failures++; $display("FAIL read_gnt_cycle1 got=%b want=1", r_gnt); end
    r_req = 1'b0;
    tick();
    checks++;
    if (ram_addr !== 4'd3) begin failures++; $display("FAIL read_ram_addr_cycle2 got=%0d want=3", ram_addr); end
    tick();
    checks++;
    if (r_valid !== 1'b0) begin failures++; $display("FAIL read_valid_early got=%b want=0", r_valid); end
    tick();
    checks++;
    if (r_valid !== 1'b1 || rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL read_valid_cycle4 valid=%b rdata=%h want 1/12345678", r_valid, rdata);
    end
    tick();
    checks++;
    if (r_valid !== 1'b0) begin failures++; $display("FAIL read_valid_pulse got=%b want=0", r_valid); end
    // Second access from idle reuses the helper.
    do_access(0, 4'd3, 1'b0, 32'd0, g, ve, v, rd, wn);
    checks++;
    if (!(g && !ve && v && wn == 0)) begin
      failures++; $display("FAIL read_helper_timing g=%b early=%b v=%b wren=%0d", g, ve, v, wn);
    end
  endtask

  task automatic test_write_then_read();
    logic g, ve, v; logic [31:0] rd; int wn;
    do_reset();
    do_access(1, 4'd5, 1'b1, 32'hAAAA_0003, g, ve, v, rd, wn);
    checks++;
    if (!(g && !ve && v)) begin failures++; $display("FAIL write_handshake g=%b early=%b v=%b", g, ve, v); end
    checks++;
    if (wn != 1) begin failures++; $display("FAIL write_wren_cycles got=%0d want=1", wn); end
    model_mem[5] = 32'hAAAA_0003;
    do_access(0, 4'd5, 1'b0, 32'd0, g, ve, v, rd, wn);
    checks++;
    if (!(g && v && wn == 0 && rd === 32'hAAAA_0003)) begin
      failures++; $display("FAIL write_readback rdata=%h want=aaaa0003 wren=%0d", rd, wn);
    end
  endtask

  task automatic test_round_robin();
    int seq[$]; int stamp[$]; int cyc;
    do_reset();
    p0_req = 1'b1; p1_req = 1'b1;
    cyc = 0;
    while (seq.size() < 4 && cyc < 40) begin
      tick(); cyc++;
      if (p0_gnt) begin seq.push_back(1); stamp.push_back(cyc); end
      if (p1_gnt) begin seq.push_back(2); stamp.push_back(cyc); end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (seq.size() != 4) begin
      failures++; $display("FAIL rr_grant_count got=%0d want=4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seq[i] != ((i % 2) + 1) || (i > 0 && stamp[i] - stamp[i-1] != 3)) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=p%0d want=p%0d", i, seq[i] - 1, i % 2);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int seq[$]; int cyc;
    do_reset();
    r_req = 1'b1; r_addr = 4'd1; p1_req = 1'b1; p1_addr = 4'd2;
    cyc = 0;
    while (seq.size() < STARVE_MAX + 2 && cyc < 100) begin
      tick(); cyc++;
      if (r_gnt) seq.push_back(0);
      if (p1_gnt) begin seq.push_back(2); p1_req = 1'b0; end
    end
    r_req = 1'b0; p1_req = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (seq.size() != STARVE_MAX + 2) begin
      failures++; $display("FAIL starve_grant_count got=%0d want=%0d", seq.size(), STARVE_MAX + 2);
    end else begin
      for (int i = 0; i < STARVE_MAX + 2; i++) begin
        checks++;
        if (seq[i] != ((i == STARVE_MAX) ? 2 : 0)) begin
          failures++; $display("FAIL starve_order idx=%0d got=%0d want=%0d", i, seq[i], (i == STARVE_MAX) ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_lock_timeout();
    int cyc, to_n, to_cyc, early, r_cyc;
    do_reset();
    p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 4'd4;
    tick();
    checks++;
    if (p0_gnt !== 1'b1) begin failures++; $display("FAIL lock_first_gnt got=%b want=1", p0_gnt); end
    p0_req = 1'b0; r_req = 1'b1; r_addr = 4'd6;
    cyc = 0; to_n = 0; to_cyc = -1; early = 0; r_cyc = -1;
    while (r_cyc < 0 && cyc < 200) begin
      tick(); cyc++;
      if (lock_timeout) begin to_n++; to_cyc = cyc; end
      if ((r_gnt || p1_gnt || p0_gnt) && to_n == 0) early++;
      if (r_gnt && to_n > 0) r_cyc = cyc;
    end
    r_req = 1'b0; p0_lock = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (early != 0) begin failures++; $display("FAIL lock_blocks_others got=%0d grants want=0", early); end
    checks++;
    if (to_n != 1 || to_cyc != LOCK_MAX) begin
      failures++; $display("FAIL lock_timeout_pulse count=%0d at=%0d want 1 at %0d", to_n, to_cyc, LOCK_MAX);
    end
    checks++;
    if (r_cyc < 0) begin failures++; $display("FAIL lock_renderer_resume got=none want=r_gnt"); end
  endtask

  task automatic test_reset_midflight();
    logic g, ve, v; logic [31:0] rd; int wn, bad;
    do_reset();
    preload(4'd7, 32'hDEAD_0007);
    p1_req = 1'b1; p1_addr = 4'd7;
    tick();
    checks++;
    if (p1_gnt !== 1'b1) begin failures++; $display("FAIL mid_p1_gnt got=%b want=1", p1_gnt); end
    p1_req = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    checks++;
    if ({p1_gnt, p1_valid, r_valid, ram_wren, lock_timeout, ram_addr, rdata} !== 41'd0) begin
      failures++; $display("FAIL mid_reset_outputs ram_addr=%h ram_wren=%b rdata=%h want 0", ram_addr, ram_wren, rdata);
    end
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (p1_valid) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mid_no_valid got=%0d want=0", bad); end
    do_access(0, 4'd3, 1'b0, 32'd0, g, ve, v, rd, wn);
    checks++;
    if (!(g && !ve && v && rd === model_mem[3])) begin
      failures++; $display("FAIL mid_recover rdata=%h want=%h g=%b v=%b", rd, model_mem[3], g, v);
    end
  endtask

  task automatic test_random_rw();
    logic g, ve, v; logic [31:0] rd, d; logic [3:0] a; logic w; int src, wn;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      src = $urandom_range(0, 2);
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      w = (src == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      do_access(src, a, w, d, g, ve, v, rd, wn);
      checks++;
      if (!(g && !ve && v && wn == int'(w))) begin
        failures++; $display("FAIL rand_handshake n=%0d src=%0d g=%b early=%b v=%b wren=%0d", n, src, g, ve, v, wn);
      end
      if (w) begin
        model_mem[a] = d;
      end else begin
        checks++;
        if (rd !== model_mem[a]) begin
          failures++; $display("FAIL rand_rdata n=%0d addr=%0d got=%h want=%h", n, a, rd, model_mem[a]);
        end
      end
    end
  endtask

  task automatic test_random_arb();
    int starve, mask, want; logic rr; logic [2:0] got, exp_oh;
    do_reset();
    starve = 0; rr = 1'b0;
    for (int n = 0; n < 48; n++) begin
      mask = $urandom_range(1, 7);
      if (mask[0] && !(starve >= STARVE_MAX && mask[2:1] != 0)) want = 0;
      else if (rr == 1'b0) want = mask[1] ? 1 : 2;
      else want = mask[2] ? 2 : 1;
      r_req = mask[0]; p0_req = mask[1]; p1_req = mask[2];
      r_addr = 4'($urandom); p0_addr = 4'($urandom); p1_addr = 4'($urandom);
      tick();
      got = {p1_gnt, p0_gnt, r_gnt};
      exp_oh = 3'b001 << want;
      checks++;
      if (got !== exp_oh) begin
        failures++; $display("FAIL rand_arb n=%0d mask=%0d got=%b want=%b", n, mask, got, exp_oh);
      end
      if (want == 0) starve = (mask[2:1] != 0) ? starve + 1 : 0;
      else begin starve = 0; rr = (want == 1); end
      clear_inputs();
      tick(); tick(); tick();
    end
  endtask

  initial begin
    pre_we = 1'b0; pre_addr = 4'd0; pre_data = 32'd0;
    resetn = 1'b0;
    clear_inputs();
    for (int i = 0; i < 16; i++) preload(4'(i), 32'hC0DE_0000 | 32'(i));
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_round_robin();
    test_starvation();
    test_lock_timeout();
    test_reset_midflight();
    test_random_rw();
    test_random_arb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
